memory_game_seq_engine: RTL and testbench
=========================================

Name: memory_game_seq_engine

Overview:
Parametrised successor to the 4-bit LFSR/storage/compare path of the memory game. It generates a growing pseudo-random symbol sequence, stores up to DEPTH symbols, and plays the sequence back for display. It then accepts player guesses over a valid/ready handshake, compares each guess against the stored symbol, and tracks level, score, win and loss. It sits between the display/keypad front-end and the game top level.

Parameters:
WIDTH, 4, bits per symbol (1..16)
DEPTH, 8, maximum sequence length; reaching it completes the game (2..64)
SHOW_CYCLES, 4, cycles each symbol is held on show_symbol (>=1)
SEED, 16'hACE1, LFSR reset value (must be nonzero)
TIMEOUT_CYCLES, 255, guess timeout in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  begin a new game (sampled in IDLE, LOSE, WIN)
guess  in  WIDTH  player symbol
guess_valid  in  1  guess present
guess_ready  out  1  engine accepting guesses
show_valid  out  1  show_symbol is meaningful
show_symbol  out  WIDTH  symbol being displayed
level  out  $clog2(DEPTH+1)  current sequence length
score  out  $clog2(DEPTH+1)  rounds completed
game_over  out  1  game ended (win or loss)
game_won  out  1  ended with all DEPTH rounds correct
timeout  out  1  loss caused by timeout (tied 0 without the macro)

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, lfsr=SEED, level=0, score=0, idx=0. All outputs are 0 immediately. Sequence memory is not cleared.
- LFSR: 16-bit Fibonacci, free-running every cycle out of reset. Shift left; new bit0 = b15^b13^b12^b10. Random symbol = lfsr[WIDTH-1:0].
- IDLE: start=1 -> GEN. level, score, game_over, game_won and timeout are cleared.
- GEN (1 cycle): mem[level] <= current symbol; level <= level+1; idx <= 0 -> SHOW.
- SHOW: each symbol mem[idx] is driven with show_valid=1 for SHOW_CYCLES cycles, then show_valid=0 for 1 blank cycle. idx advances after the blank. After the blank of the last symbol (idx==level-1): idx <= 0 -> INPUT. show_symbol=0 whenever show_valid=0.
- INPUT: guess_ready=1. A transfer occurs when guess_valid & guess_ready on the same edge. guess_valid outside INPUT is ignored.
  - guess != mem[idx] -> LOSE.
  - guess == mem[idx] and idx<level-1 -> idx+1.
  - guess == mem[idx] and idx==level-1 -> score+1; then WIN if level==DEPTH, else GEN.
- guess_ready deasserts the cycle after the transfer that leaves INPUT.
- LOSE: game_over=1, game_won=0; state held.
- WIN: game_over=1, game_won=1, score=DEPTH; state held.
- start in LOSE or WIN behaves as in IDLE (new game, new symbols). start in GEN, SHOW or INPUT is ignored.
- Comparison is a full WIDTH-bit equality; no partial credit.
- Reset mid-game: immediate return to IDLE; a new game needs start.

Optional Feature:
Macro GUESS_TIMEOUT_EN.
- Defined: a counter clears on INPUT entry and on every accepted guess, and increments each INPUT cycle. When it reaches TIMEOUT_CYCLES with no guess -> LOSE with timeout=1. timeout clears on start or reset.
- Undefined: no counter; INPUT waits indefinitely; timeout is constant 0.

Decomposition:
- Package memory_game_pkg holds:
  - state enum (IDLE, GEN, SHOW, INPUT, LOSE, WIN)
  - LFSR width constant 16
  - tap mask 16'hB400
  - default SEED
- Sub-module seq_lfsr: parametrised seed, async active-low reset, exposes the 16-bit state. The top slices WIDTH bits from it.
- Memory is an internal register array; no separate RAM module.

Test Plan:
- Assert RST_N low mid-SHOW (DEPTH=4) -> show_valid, guess_ready, level, score, game_over all 0 in the same cycle; state IDLE; start needed to resume.
- start pulse, SHOW_CYCLES=4 -> GEN 1 cycle; show_valid=1 for 4 cycles then 0 for 1; guess_ready=1 next cycle; level=1; show_symbol equals the model LFSR low bits at GEN.
- DEPTH=4, bench echoes every displayed symbol -> level steps 1,2,3,4; score=4; game_won=1, game_over=1; guess_ready=0 afterwards.
- Round 3, wrong guess at idx 1 -> game_over=1, game_won=0, score=2, guess_ready=0 the following cycle; start then gives level=1, score=0.
- guess_valid held high through SHOW and GEN -> no transfer, idx and state unchanged; the first guess is accepted only once guess_ready=1.
- GUESS_TIMEOUT_EN, TIMEOUT_CYCLES=16, no guess -> timeout=1 and game_over=1 exactly 16 cycles after guess_ready rises; an accepted guess at cycle 10 restarts the count.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game sequence engine.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW,
    INPUT,
    LOSE,
    WIN
  } state_e;

  localparam int              LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Taps at bits 15, 13, 12 and 10 of the Fibonacci register.
  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies random symbols to the engine.
module seq_lfsr
  import memory_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  assign lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_feedback(lfsr_q)};
  assign state_o = lfsr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/memory_game_seq_engine.sv
// Memory game engine: grows a random symbol sequence, plays it back, then scores guesses.
// Optional guess timeout is enabled by defining GUESS_TIMEOUT_EN.
module memory_game_seq_engine
  import memory_game_pkg::*;
#(
  parameter int                WIDTH          = 4,
  parameter int                DEPTH          = 8,
  parameter int                SHOW_CYCLES    = 4,
  parameter logic [LFSR_W-1:0] SEED           = DEFAULT_SEED,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic [WIDTH-1:0]             guess,
  input  logic                         guess_valid,
  output logic                         guess_ready,
  output logic                         show_valid,
  output logic [WIDTH-1:0]             show_symbol,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   score,
  output logic                         game_over,
  output logic                         game_won,
  output logic                         timeout
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CYC_W = $clog2(SHOW_CYCLES + 1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d, score_q, score_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [LFSR_W-1:0] lfsr;
  logic [WIDTH-1:0]  rand_sym, cur_sym;
  logic              xfer, last, hit, to_expire;
  logic              unused_bits;

  seq_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .state_o (lfsr)
  );

  assign rand_sym    = lfsr[WIDTH-1:0];
  assign cur_sym     = mem_q[idx_q];
  assign xfer        = (state_q == INPUT) && guess_valid;
  assign last        = (LVL_W'(idx_q) == level_q - LVL_W'(1));
  assign hit         = (guess == cur_sym);
  assign unused_bits = ^{lfsr, 32'(TIMEOUT_CYCLES)};

`ifdef GUESS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter runs only while waiting in INPUT; any accepted guess or leaving INPUT clears it.
  assign to_cnt_d  = (state_q == INPUT && !guess_valid) ? to_cnt_q + 1'b1 : '0;
  assign to_expire = (state_q == INPUT) && !guess_valid &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      level_q   <= '0;
      score_q   <= '0;
      idx_q     <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      score_q   <= score_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  // Sequence storage keeps its contents across reset; only GEN writes it.
  always_ff @(posedge CLK) begin
    if (state_q == GEN) mem_q[level_q[IDX_W-1:0]] <= rand_sym;
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    score_d   = score_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, LOSE, WIN: begin
        if (start) begin
          state_d   = GEN;
          level_d   = '0;
          score_d   = '0;
          timeout_d = 1'b0;
        end
      end
      GEN: begin
        level_d = level_q + 1'b1;
        idx_d   = '0;
        cyc_d   = '0;
        state_d = SHOW;
      end
      SHOW: begin
        // Cycles 0..SHOW_CYCLES-1 display the symbol, cycle SHOW_CYCLES is the blank gap.
        if (cyc_q == CYC_W'(SHOW_CYCLES)) begin
          cyc_d = '0;
          if (last) begin
            idx_d   = '0;
            state_d = INPUT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      INPUT: begin
        if (xfer) begin
          if (!hit) begin
            state_d = LOSE;
          end else if (!last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            score_d = score_q + 1'b1;
            state_d = (level_q == LVL_W'(DEPTH)) ? WIN : GEN;
          end
        end else if (to_expire) begin
          state_d   = LOSE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    guess_ready = (state_q == INPUT);
    show_valid  = (state_q == SHOW) && (cyc_q < CYC_W'(SHOW_CYCLES));
    show_symbol = show_valid ? cur_sym : '0;
    level       = level_q;
    score       = score_q;
    game_over   = (state_q == LOSE) || (state_q == WIN);
    game_won    = (state_q == WIN);
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_memory_game_seq_engine.sv
// Scoreboard bench for memory_game_seq_engine (DEPTH=4, SHOW_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_memory_game_seq_engine;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int SHOW  = 4;
  localparam int TO    = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] guess = '0;
  logic             guess_valid = 1'b0;
  logic             guess_ready, show_valid, game_over, game_won, timeout;
  logic [WIDTH-1:0] show_symbol;
  logic [LW-1:0]    level, score;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0]      mdl;
  logic [WIDTH-1:0] seq [$];
  logic [WIDTH-1:0] show_q [$];

  memory_game_seq_engine #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SHOW_CYCLES(SHOW),
    .SEED(16'hACE1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .guess(guess),
    .guess_valid(guess_valid), .guess_ready(guess_ready),
    .show_valid(show_valid), .show_symbol(show_symbol),
    .level(level), .score(score), .game_over(game_over),
    .game_won(game_won), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR straight from the polynomial description.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mdl <= 16'hACE1;
    else        mdl <= {mdl[14:0], mdl[15] ^ mdl[13] ^ mdl[12] ^ mdl[10]};
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired: got no finish, want finish");
    $fatal(1);
  end

  task automatic start_game();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    seq.delete();
    n_checks++;
    if ({level, score, game_over, game_won, timeout} !== '0)
      $display("FAIL start_clear got lvl=%0d sc=%0d go=%b gw=%b to=%b want all 0",
               level, score, game_over, game_won, timeout);
    else n_pass++;
  endtask

  // Entered at a GEN-cycle negedge; leaves at the first INPUT-cycle negedge.
  task automatic do_show(input bit hold);
    logic [WIDTH-1:0] e;
    seq.push_back(mdl[WIDTH-1:0]);
    n_checks++;
    if ({show_valid, guess_ready} !== 2'b00)
      $display("FAIL gen_outputs got sv=%b gr=%b want 0 0", show_valid, guess_ready);
    else n_pass++;
    if (hold) begin
      guess_valid = 1'b1;
      guess       = seq[0] ^ 4'hF;
    end
    foreach (seq[k]) show_q.push_back(seq[k]);
    for (int i = 0; i < seq.size(); i++) begin
      e = show_q.pop_front();
      for (int c = 0; c < SHOW; c++) begin
        @(negedge CLK);
        n_checks++;
        if (show_valid !== 1'b1 || show_symbol !== e)
          $display("FAIL show_sym i=%0d c=%0d got v=%b s=%h want v=1 s=%h",
                   i, c, show_valid, show_symbol, e);
        else n_pass++;
      end
      @(negedge CLK);
      n_checks++;
      if ({show_valid, show_symbol} !== '0)
        $display("FAIL show_blank i=%0d got v=%b s=%h want v=0 s=0", i, show_valid, show_symbol);
      else n_pass++;
    end
    @(negedge CLK);
    n_checks++;
    if (guess_ready !== 1'b1 || level !== LW'(seq.size()) || game_over !== 1'b0)
      $display("FAIL input_entry got gr=%b lvl=%0d go=%b want gr=1 lvl=%0d go=0",
               guess_ready, level, game_over, seq.size());
    else n_pass++;
  endtask

  task automatic do_guesses(input int wrong_at);
    for (int i = 0; i < seq.size(); i++) begin
      guess_valid = 1'b1;
      guess       = (i == wrong_at) ? (seq[i] ^ 4'h1) : seq[i];
      @(negedge CLK);
      if (i == wrong_at) break;
      if (i < seq.size() - 1) begin
        n_checks++;
        if (guess_ready !== 1'b1 || game_over !== 1'b0)
          $display("FAIL mid_guess i=%0d got gr=%b go=%b want gr=1 go=0", i, guess_ready, game_over);
        else n_pass++;
      end
    end
    guess_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({show_valid, show_symbol, guess_ready, level, score, game_over, game_won, timeout} !== '0)
      $display("FAIL reset_outputs got nonzero outputs want all 0");
    else n_pass++;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({show_valid, guess_ready, level, game_over} !== '0)
      $display("FAIL idle_hold got sv=%b gr=%b lvl=%0d go=%b want 0", show_valid, guess_ready, level, game_over);
    else n_pass++;
  endtask

  task automatic test_full_win();
    start_game();
    for (int r = 1; r <= DEPTH; r++) begin
      do_show(1'b0);
      do_guesses(-1);
      n_checks++;
      if (r < DEPTH) begin
        if (score !== LW'(r) || guess_ready !== 1'b0 || game_over !== 1'b0)
          $display("FAIL round_done r=%0d got sc=%0d gr=%b go=%b want sc=%0d gr=0 go=0",
                   r, score, guess_ready, game_over, r);
        else n_pass++;
      end else begin
        if ({game_over, game_won, guess_ready} !== 3'b110 || score !== LW'(DEPTH) || level !== LW'(DEPTH))
          $display("FAIL win got go=%b gw=%b gr=%b sc=%0d lvl=%0d want 1 1 0 %0d %0d",
                   game_over, game_won, guess_ready, score, level, DEPTH, DEPTH);
        else n_pass++;
      end
    end
    guess_valid = 1'b1;
    guess       = seq[0];
    repeat (3) @(negedge CLK);
    guess_valid = 1'b0;
    n_checks++;
    if ({game_over, game_won, guess_ready} !== 3'b110 || score !== LW'(DEPTH))
      $display("FAIL win_hold got go=%b gw=%b gr=%b sc=%0d want 1 1 0 %0d",
               game_over, game_won, guess_ready, score, DEPTH);
    else n_pass++;
  endtask

  task automatic test_wrong_guess();
    start_game();
    for (int r = 1; r <= 2; r++) begin
      do_show(1'b0);
      do_guesses(-1);
    end
    do_show(1'b0);
    do_guesses(1);
    n_checks++;
    if ({game_over, game_won, guess_ready} !== 3'b100 || score !== LW'(2))
      $display("FAIL lose got go=%b gw=%b gr=%b sc=%0d want 1 0 0 2",
               game_over, game_won, guess_ready, score);
    else n_pass++;
    start_game();
    do_show(1'b0);
    n_checks++;
    if (score !== '0)
      $display("FAIL restart_score got %0d want 0", score);
    else n_pass++;
    do_guesses(-1);
  endtask

  task automatic test_guess_during_show();
    do_show(1'b1);
    do_guesses(-1);
    n_checks++;
    if (score !== LW'(2) || game_over !== 1'b0)
      $display("FAIL hold_valid got sc=%0d go=%b want sc=2 go=0", score, game_over);
    else n_pass++;
  endtask

  task automatic test_reset_mid_show();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (show_valid !== 1'b1)
      $display("FAIL pre_reset_show got %b want 1", show_valid);
    else n_pass++;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({show_valid, guess_ready, level, score, game_over} !== '0)
      $display("FAIL reset_mid_show got sv=%b gr=%b lvl=%0d sc=%0d go=%b want all 0",
               show_valid, guess_ready, level, score, game_over);
    else n_pass++;
    @(negedge CLK); RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    n_checks++;
    if ({show_valid, guess_ready, level} !== '0)
      $display("FAIL post_reset_idle got sv=%b gr=%b lvl=%0d want 0", show_valid, guess_ready, level);
    else n_pass++;
    start_game();
    do_show(1'b0);
    do_guesses(-1);
    n_checks++;
    if (score !== LW'(1))
      $display("FAIL post_reset_round got sc=%0d want 1", score);
    else n_pass++;
  endtask

  task automatic test_timeout();
`ifdef GUESS_TIMEOUT_EN
    do_show(1'b0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge CLK);
      if (k == TO - 1 || k == TO) begin
        n_checks++;
        if (game_over !== (k == TO) || timeout !== (k == TO))
          $display("FAIL timeout_rise k=%0d got go=%b to=%b want %0d", k, game_over, timeout, k == TO);
        else n_pass++;
      end
    end
    start_game();
    do_show(1'b0);
    do_guesses(-1);
    do_show(1'b0);
    repeat (10) @(negedge CLK);
    guess_valid = 1'b1;
    guess       = seq[0];
    @(negedge CLK);
    guess_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge CLK);
      if (k == TO - 1 || k == TO) begin
        n_checks++;
        if (game_over !== (k == TO) || timeout !== (k == TO) || game_won !== 1'b0)
          $display("FAIL timeout_restart k=%0d got go=%b to=%b want %0d", k, game_over, timeout, k == TO);
        else n_pass++;
      end
    end
    start_game();
`else
    do_show(1'b0);
    repeat (TO * 3) @(negedge CLK);
    n_checks++;
    if (guess_ready !== 1'b1 || game_over !== 1'b0 || timeout !== 1'b0)
      $display("FAIL no_timeout got gr=%b go=%b to=%b want 1 0 0", guess_ready, game_over, timeout);
    else n_pass++;
    do_guesses(-1);
`endif
  endtask

  initial begin
    test_reset();
    test_full_win();
    test_wrong_guess();
    test_guess_during_show();
    test_reset_mid_show();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
